// File: rtl/dmem_pkg.sv
// Shared types and helpers for the pipelined data memory: access sizes,
// store strobe generation and load lane extraction/extension.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  function automatic logic [3:0] size_lane_to_strb(size_e sz, logic [1:0] lane);
    logic [3:0] strb;
    strb = '0;
    case (sz)
      SZ_B:    strb = 4'b0001 << lane;
      SZ_H:    strb = 4'b0011 << lane;
      SZ_W:    strb = 4'b1111;
      default: strb = '0;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] extend_load(logic [31:0] word, size_e sz,
                                              logic [1:0] lane, logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      SZ_B:    res = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_H:    res = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// Synchronous response FIFO; head entry is presented on rdata while not empty.
module dmem_rsp_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dmem_pipe.sv
// Pipelined byte/half/word data memory with configurable read latency,
// error flagging and an in-order response FIFO bounded by an outstanding count.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned MAX_OUT = RD_LATENCY + 1;
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned CW      = $clog2(MAX_OUT + 1);
  localparam logic [31:0] SPAN    = 32'(DEPTH) << 2;

  logic [3:0][7:0] mem [DEPTH];

  logic [CW-1:0] outstanding;
  logic          accept, consume;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  size_e         sz;
  logic          err;
  logic [3:0]    strb;
  logic [31:0]   wrep;
  logic [32:0]   rsp_in;
  logic          push_v, fifo_push, fifo_full, fifo_empty;
  logic [32:0]   push_data, head;

  assign req_ready = !rst && (outstanding < CW'(MAX_OUT));
  assign accept    = req_valid && req_ready;
  assign consume   = rsp_valid && rsp_ready;

  always_comb begin
    off  = req_addr - BASE_ADDR;
    idx  = off[AW+1:2];
    lane = off[1:0];
    sz   = size_e'(req_size);
    err  = (off >= SPAN) || (sz == SZ_X) ||
           ((sz == SZ_H) && lane[0]) || ((sz == SZ_W) && (lane != 2'd0));
    strb = size_lane_to_strb(sz, lane);
    case (sz)
      SZ_B:    wrep = {4{req_wdata[7:0]}};
      SZ_H:    wrep = {2{req_wdata[15:0]}};
      default: wrep = req_wdata;
    endcase
    // Loads read the array combinationally, so stores from earlier edges are visible.
    rsp_in = {err, (req_we || err) ? 32'h0 : extend_load(mem[idx], sz, lane, req_unsigned)};
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (strb[b]) mem[idx][b] <= wrep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({accept, consume})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  if (RD_LATENCY == 1) begin : g_direct
    assign push_v    = accept;
    assign push_data = rsp_in;
  end else begin : g_pipe
    logic [RD_LATENCY-2:0] pv;
    logic [32:0]           pd [RD_LATENCY-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        pv <= '0;
      end else begin
        pv[0] <= accept;
        for (int unsigned i = 1; i < RD_LATENCY - 1; i++) pv[i] <= pv[i-1];
      end
    end

    always_ff @(posedge clk) begin
      pd[0] <= rsp_in;
      for (int unsigned i = 1; i < RD_LATENCY - 1; i++) pd[i] <= pd[i-1];
    end

    assign push_v    = pv[RD_LATENCY-2];
    assign push_data = pd[RD_LATENCY-2];
  end

  // The outstanding bound already guarantees space; gating on full is defensive.
  assign fifo_push = push_v && !fifo_full;

  dmem_rsp_fifo #(
    .WIDTH (33),
    .DEPTH (MAX_OUT)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (push_data),
    .pop   (consume),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_err   = fifo_empty ? 1'b0 : head[32];
  assign rsp_rdata = fifo_empty ? 32'h0 : head[31:0];

endmodule
